// File: rtl/mm_tile_if.sv
// Handshake/bus bundle between the tile sequencer and its surroundings.
// Widths are derived from the same geometry parameters that the sequencer uses.
interface mm_tile_if #(
    parameter int M_TILES   = 32,
    parameter int N_TILES   = 32,
    parameter int K         = 256,
    parameter int VEC_BITS  = 256,
    parameter int ACC_DEPTH = 16
);
    localparam int KS8    = K * 8 / VEC_BITS;
    localparam int A_AW   = (M_TILES * KS8 > 1) ? $clog2(M_TILES * KS8) : 1;
    localparam int B_AW   = (N_TILES * ACC_DEPTH * KS8 > 1) ? $clog2(N_TILES * ACC_DEPTH * KS8) : 1;
    localparam int ACC_AW = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
    localparam int M_W    = (M_TILES > 1) ? $clog2(M_TILES) : 1;
    localparam int N_W    = (N_TILES > 1) ? $clog2(N_TILES) : 1;

    logic              i_start;
    logic [1:0]        i_mode;
    logic              i_drain_rdy;
    logic [1:0]        o_mode;
    logic              o_busy;
    logic              o_rd_en;
    logic [A_AW-1:0]   o_a_addr;
    logic [B_AW-1:0]   o_b_addr;
    logic              o_acc_we;
    logic [ACC_AW-1:0] o_acc_addr;
    logic              o_psum_clr;
    logic              o_drain_vld;
    logic [M_W-1:0]    o_drain_m;
    logic [N_W-1:0]    o_drain_n;
    logic              o_done;

    modport master (
        output i_start, i_mode, i_drain_rdy,
        input  o_mode, o_busy, o_rd_en, o_a_addr, o_b_addr, o_acc_we, o_acc_addr,
               o_psum_clr, o_drain_vld, o_drain_m, o_drain_n, o_done
    );

    modport slave (
        input  i_start, i_mode, i_drain_rdy,
        output o_mode, o_busy, o_rd_en, o_a_addr, o_b_addr, o_acc_we, o_acc_addr,
               o_psum_clr, o_drain_vld, o_drain_m, o_drain_n, o_done
    );
endinterface

// File: rtl/mm_tile_ctrl.sv
// Tile sequencer for the MAC array: walks M/N tiles, K-steps and accumulator
// columns, issues buffer reads, delays the accumulator write strobes and drains tiles.
module mm_tile_ctrl #(
    parameter int M_TILES   = 32,
    parameter int N_TILES   = 32,
    parameter int K         = 256,
    parameter int VEC_BITS  = 256,
    parameter int ACC_DEPTH = 16,
    parameter int RD_LAT    = 1
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    mm_tile_if.slave bus
);
    localparam int KS8    = K * 8 / VEC_BITS;
    localparam int KS4    = K * 4 / VEC_BITS;
    localparam int KS_W   = $clog2(KS8 + 1);
    localparam int A_AW   = (M_TILES * KS8 > 1) ? $clog2(M_TILES * KS8) : 1;
    localparam int B_AW   = (N_TILES * ACC_DEPTH * KS8 > 1) ? $clog2(N_TILES * ACC_DEPTH * KS8) : 1;
    localparam int ACC_AW = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
    localparam int M_W    = (M_TILES > 1) ? $clog2(M_TILES) : 1;
    localparam int N_W    = (N_TILES > 1) ? $clog2(N_TILES) : 1;
    localparam int FL_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [ACC_AW-1:0] C_LAST  = ACC_AW'(ACC_DEPTH - 1);
    localparam logic [M_W-1:0]    M_LAST  = M_W'(M_TILES - 1);
    localparam logic [N_W-1:0]    N_LAST  = N_W'(N_TILES - 1);
    localparam logic [FL_W-1:0]   FL_LAST = FL_W'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [M_W-1:0]    m, m_nxt;
    logic [N_W-1:0]    n, n_nxt;
    logic [KS_W-1:0]   k, k_nxt;
    logic [ACC_AW-1:0] c, c_nxt;
    logic [ACC_AW-1:0] d, d_nxt;
    logic [FL_W-1:0]   fl, fl_nxt;
    logic [1:0]        mode, mode_nxt;

    logic [RD_LAT-1:0]             pipe_we;
    logic [RD_LAT-1:0]             pipe_clr;
    logic [RD_LAT-1:0][ACC_AW-1:0] pipe_c;

    logic            issue;
    logic            narrow;
    logic [KS_W-1:0] ks_last;
    int              ks_int;
    int              a_full;
    int              b_full;

    assign issue   = (state == RUN);
    assign narrow  = (mode == 2'd1) || (mode == 2'd2);
    assign ks_last = narrow ? KS_W'(KS4 - 1) : KS_W'(KS8 - 1);
    assign ks_int  = narrow ? KS4 : KS8;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            m        <= '0;
            n        <= '0;
            k        <= '0;
            c        <= '0;
            d        <= '0;
            fl       <= '0;
            mode     <= '0;
            pipe_we  <= '0;
            pipe_clr <= '0;
            pipe_c   <= '0;
        end else begin
            state       <= state_nxt;
            m           <= m_nxt;
            n           <= n_nxt;
            k           <= k_nxt;
            c           <= c_nxt;
            d           <= d_nxt;
            fl          <= fl_nxt;
            mode        <= mode_nxt;
            // Issue-stage write info travels RD_LAT stages to line up with read data.
            pipe_we[0]  <= issue;
            pipe_clr[0] <= issue && (k == '0);
            pipe_c[0]   <= issue ? c : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_we[i]  <= pipe_we[i-1];
                pipe_clr[i] <= pipe_clr[i-1];
                pipe_c[i]   <= pipe_c[i-1];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        m_nxt     = m;
        n_nxt     = n;
        k_nxt     = k;
        c_nxt     = c;
        d_nxt     = d;
        fl_nxt    = fl;
        mode_nxt  = mode;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nxt = RUN;
                    mode_nxt  = bus.i_mode;
                    m_nxt     = '0;
                    n_nxt     = '0;
                    k_nxt     = '0;
                    c_nxt     = '0;
                    d_nxt     = '0;
                end
            end
            RUN: begin
                if (c == C_LAST) begin
                    c_nxt = '0;
                    if (k == ks_last) begin
                        k_nxt     = '0;
                        fl_nxt    = '0;
                        state_nxt = FLUSH;
                    end else begin
                        k_nxt = k + 1'b1;
                    end
                end else begin
                    c_nxt = c + 1'b1;
                end
            end
            FLUSH: begin
                if (fl == FL_LAST) begin
                    state_nxt = DRAIN;
                    d_nxt     = '0;
                end else begin
                    fl_nxt = fl + 1'b1;
                end
            end
            DRAIN: begin
                if (bus.i_drain_rdy) begin
                    if (d == C_LAST) begin
                        d_nxt = '0;
                        if (m == M_LAST && n == N_LAST) begin
                            state_nxt = DONE;
                        end else begin
                            state_nxt = RUN;
                            if (n == N_LAST) begin
                                n_nxt = '0;
                                m_nxt = m + 1'b1;
                            end else begin
                                n_nxt = n + 1'b1;
                            end
                        end
                    end else begin
                        d_nxt = d + 1'b1;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Addresses are zero whenever no read is being issued.
    always_comb begin
        a_full = 0;
        b_full = 0;
        if (issue) begin
            a_full = int'(m) * ks_int + int'(k);
            b_full = (int'(n) * ACC_DEPTH + int'(c)) * ks_int + int'(k);
        end
    end

    assign bus.o_mode      = mode;
    assign bus.o_busy      = (state != IDLE);
    assign bus.o_rd_en     = issue;
    assign bus.o_a_addr    = A_AW'(a_full);
    assign bus.o_b_addr    = B_AW'(b_full);
    assign bus.o_acc_we    = pipe_we[RD_LAT-1];
    assign bus.o_psum_clr  = pipe_clr[RD_LAT-1];
    assign bus.o_acc_addr  = (state == DRAIN) ? d : pipe_c[RD_LAT-1];
    assign bus.o_drain_vld = (state == DRAIN);
    assign bus.o_drain_m   = m;
    assign bus.o_drain_n   = n;
    assign bus.o_done      = (state == DONE);
endmodule

// File: doc/mm_tile_ctrl.md
# mm_tile_ctrl

Parametrised sequencer for the tiled matrix-multiply datapath. It walks output tiles (M-tile × N-tile), K-steps and accumulator columns, and drives the A/B buffer read addresses, accumulator write/clear strobes and a valid/ready drain of each finished tile. It replaces the hand-driven address/we registers around the MAC array and adds a done pulse and precision-dependent K-step counts.

## Interface
- M_TILES, 32: row tiles (rows/LANES)
- N_TILES, 32: column tiles (columns/ACC_DEPTH)
- K, 256: reduction length in elements
- VEC_BITS, 256: payload bits per buffer word; KS8 = K*8/VEC_BITS, KS4 = K*4/VEC_BITS (both ≥1, integer)
- ACC_DEPTH, 16: accumulator entries per tile (> RD_LAT)
- RD_LAT, 1: buffer read latency in cycles (≥1)
- Derived: KS_W = clog2(KS8+1), A_AW = clog2(M_TILES*KS8), B_AW = clog2(N_TILES*ACC_DEPTH*KS8), ACC_AW = clog2(ACC_DEPTH)
- i_clk  in  1  clock; rising edge
- i_rst_n  in  1  reset, synchronous active-low
- i_start  in  1  start pulse; sampled only in IDLE
- i_mode  in  2  0 INT8, 1 INT4, 2 INT4_VSQ, 3 treated as INT8
- i_drain_rdy  in  1  downstream accepts drained entry
- o_mode  out  2  mode captured at start
- o_busy  out  1  high in every state except IDLE
- o_rd_en  out  1  A/B buffer read issued this cycle
- o_a_addr  out  A_AW  A buffer address (shared by all lanes)
- o_b_addr  out  B_AW  B buffer address
- o_acc_we  out  1  accumulator write
- o_acc_addr  out  ACC_AW  accumulator read/write address
- o_psum_clr  out  1  MAC uses zero psum (first K-step)
- o_drain_vld  out  1  accumulator entry at o_acc_addr offered downstream
- o_drain_m / o_drain_n  out  clog2(M_TILES) / clog2(N_TILES)  tile being drained
- o_done  out  1  one-cycle pulse after last tile drained

## Operation
- KS = KS8 for modes 0/3, KS4 for modes 1/2; fixed for the whole job.
- States: IDLE → RUN on i_start (capture i_mode, zero m,n,k,c counters). RUN → FLUSH after issue with k=KS-1, c=ACC_DEPTH-1. FLUSH lasts RD_LAT cycles → DRAIN. DRAIN → RUN (next tile) or DONE after accepting entry ACC_DEPTH-1. DONE → IDLE after one cycle.
- RUN loop order, innermost first: c (0..ACC_DEPTH-1), k (0..KS-1); one read issue per cycle, o_rd_en=1.
- Issue addresses: o_a_addr = m*KS + k; o_b_addr = ((n*ACC_DEPTH)+c)*KS + k. A address is stable across ACC_DEPTH consecutive cycles.
- Write side: o_acc_we, o_acc_addr=c and o_psum_clr=(k==0) are the issue-stage values delayed exactly RD_LAT cycles; psum read and write use the same o_acc_addr.
- Tile advance: n increments; at n=N_TILES-1 it wraps to 0 and m increments; after m=M_TILES-1, n=N_TILES-1 drained → DONE.
- DRAIN: o_drain_vld=1, o_acc_addr = drain index d (0..ACC_DEPTH-1), o_drain_m/n = tile just computed. d advances only on o_drain_vld & i_drain_rdy; held otherwise. o_acc_we=0 throughout.
- i_start outside IDLE ignored; i_mode changes after capture ignored.

## Timing
- Reset (i_rst_n=0 at edge): state IDLE, all counters 0, all outputs 0 (o_mode=0) on the next cycle; applies mid-job, pending writes dropped.
- Outputs registered. i_start at edge t → o_busy=1, o_rd_en=1, address (0,0) at t+1.
- First o_acc_we RD_LAT cycles after first o_rd_en; last o_acc_we in last FLUSH cycle.
- Per tile with i_drain_rdy held high: ACC_DEPTH*KS + RD_LAT + ACC_DEPTH cycles.
- o_done high the cycle after final drain handshake; o_busy low the following cycle.
- o_acc_we and o_drain_vld never high together.

## Test plan
- Reset: hold i_rst_n=0 for 3 cycles, toggle i_start → all outputs 0, state stays IDLE.
- INT8 single tile (M_TILES=N_TILES=1, K=64, VEC_BITS=256, ACC_DEPTH=4, RD_LAT=1): start → 8 issues, b_addr 0,2,4,6,1,3,5,7; a_addr 0,0,0,0,1,1,1,1; psum_clr on first 4 writes; 4 drains; o_done at cycle 14 after start.
- INT4 same params, mode=1 → KS=1: 4 issues, all with psum_clr, b_addr 0..3, o_done at cycle 10.
- Backpressure: i_drain_rdy low 5 cycles at d=2 → o_acc_addr holds 2, vld high, no advance; completion delayed exactly 5 cycles.
- Multi-tile (M_TILES=2, N_TILES=2, mode 2): drains tagged (0,0),(0,1),(1,0),(1,1); a_addr base 0,0,1,1 per tile; one o_done.
- Mid-run reset and busy start: i_start in RUN ignored; i_rst_n=0 during DRAIN → next cycle IDLE, outputs 0; fresh start reproduces scenario 2 exactly.
